io_periph_slave: RTL

Peripheral-side responder for the processor's IO window. It consumes the `io_addr` / `io_wdata` / `io_we` bus driven by the CPU's memory/IO address decoder and returns `io_rdata` combinationally in the same cycle. It owns the board-facing registers:
- LED and seven-segment data latches
- synchronized switch inputs
- debounced buttons with sticky press flags
- a 32-bit compare timer with interrupt

---
 rtl/io_periph_slave.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/io_periph_slave.sv
// Board-facing IO register window: LED/SEG latches, synchronized switches,
// debounced buttons with sticky press flags, and a 32-bit compare timer.
module io_periph_slave #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  output logic [31:0] io_rdata,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic        timer_irq
);

  localparam logic [19:0] DB_LAST = DEBOUNCE_CYCLES - 20'd1;

  logic        hit;
  logic [2:0]  offset;
  logic        wr_en;
  logic        wr_led, wr_btn, wr_seg, wr_tcnt, wr_tcmp, wr_tctrl;

  logic [15:0] led_reg;
  logic [31:0] seg_reg;
  logic [15:0] sw_meta_reg, sw_sync_reg;
  logic [4:0]  btn_meta_reg, btn_sync_reg;
  logic [4:0]  btn_level;
  logic [4:0]  btn_level_d_reg;
  logic [4:0]  flag_reg, flag_next;
  logic [31:0] tcnt_reg, tcnt_next;
  logic [31:0] tcmp_reg;
  logic        en_reg, auto_reg, irq_en_reg;
  logic        match_reg, match_next, match_set;

  assign hit      = (io_addr[31:5] == BASE_ADDR[31:5]);
  assign offset   = io_addr[4:2];
  assign wr_en    = io_we & hit;
  assign wr_led   = wr_en & (offset == 3'd0);
  assign wr_btn   = wr_en & (offset == 3'd2);
  assign wr_seg   = wr_en & (offset == 3'd3);
  assign wr_tcnt  = wr_en & (offset == 3'd4);
  assign wr_tcmp  = wr_en & (offset == 3'd5);
  assign wr_tctrl = wr_en & (offset == 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg      <= '0;
      seg_reg      <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
    end else begin
      if (wr_led) led_reg <= io_wdata[15:0];
      if (wr_seg) seg_reg <= io_wdata;
      sw_meta_reg  <= sw;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= btn;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  // Each button accepts a new level only after the synced input has
  // disagreed with the accepted level for DEBOUNCE_CYCLES consecutive cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic [19:0] cnt_reg;
      logic        level_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (btn_sync_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          cnt_reg   <= '0;
          level_reg <= btn_sync_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 20'd1;
        end
      end
      assign btn_level[gi] = level_reg;
    end
  endgenerate

  // Hardware set wins over a same-cycle W1C.
  always_comb begin
    flag_next = flag_reg;
    if (wr_btn) flag_next = flag_next & ~io_wdata[4:0];
    flag_next = flag_next | (btn_level & ~btn_level_d_reg);
  end

  always_comb begin
    tcnt_next = tcnt_reg;
    match_set = 1'b0;
    if (wr_tcnt) begin
      tcnt_next = io_wdata;
    end else if (en_reg) begin
      if (tcnt_reg == tcmp_reg) begin
        match_set = 1'b1;
        tcnt_next = auto_reg ? 32'd0 : tcnt_reg + 32'd1;
      end else begin
        tcnt_next = tcnt_reg + 32'd1;
      end
    end
    match_next = (match_reg & ~(wr_tctrl & io_wdata[8])) | match_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level_d_reg <= '0;
      flag_reg        <= '0;
      tcnt_reg        <= '0;
      tcmp_reg        <= '0;
      en_reg          <= 1'b0;
      auto_reg        <= 1'b0;
      irq_en_reg      <= 1'b0;
      match_reg       <= 1'b0;
    end else begin
      btn_level_d_reg <= btn_level;
      flag_reg        <= flag_next;
      tcnt_reg        <= tcnt_next;
      match_reg       <= match_next;
      if (wr_tcmp) tcmp_reg <= io_wdata;
      if (wr_tctrl) begin
        en_reg     <= io_wdata[0];
        auto_reg   <= io_wdata[1];
        irq_en_reg <= io_wdata[2];
      end
    end
  end

  always_comb begin
    io_rdata = 32'd0;
    if (hit) begin
      case (offset)
        3'd0:    io_rdata = {16'd0, led_reg};
        3'd1:    io_rdata = {16'd0, sw_sync_reg};
        3'd2:    io_rdata = {19'd0, btn_level, 3'd0, flag_reg};
        3'd3:    io_rdata = seg_reg;
        3'd4:    io_rdata = tcnt_reg;
        3'd5:    io_rdata = tcmp_reg;
        3'd6:    io_rdata = {23'd0, match_reg, 5'd0, irq_en_reg, auto_reg, en_reg};
        default: io_rdata = 32'd0;
      endcase
    end
  end

  assign led       = led_reg;
  assign seg_data  = seg_reg;
  assign timer_irq = match_reg & irq_en_reg;

endmodule
